// File: rtl/m_axi4l_image_sender_pkg.sv
// Shared types and constants for the image-sender AXI4-Lite master.
package snn_axi_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WADDR_DATA, S_WRESP, S_WAIT_RDY, S_RADDR, S_RDATA, S_FINISH
  } state_e;

  typedef enum logic [1:0] {WC_IDLE, WC_ADDR_DATA, WC_RESP} wc_state_e;

  // Which write is in flight: a pixel, the control "1" write or the control "0" write.
  typedef enum logic [1:0] {WS_PIX, WS_CTRL1, WS_CTRL0} wsel_e;

  localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
  localparam int unsigned CTRL_ADDR_DEF   = 256;
  localparam int unsigned RESULT_ADDR_DEF = 0;
  localparam logic [3:0]  WSTRB_BYTE0     = 4'h1;

endpackage

// File: rtl/m_axi4l_image_sender_write_channel.sv
// Single AXI4-Lite write: AW and W issued together, each dropped on its own
// READY, then BREADY held until the response arrives.
module axi4l_write_channel
  import snn_axi_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic [AXI_ADDR_WIDTH-1:0] i_addr,
  input  logic [AXI_DATA_WIDTH-1:0] i_data,
  output logic                      o_addr_done,
  output logic                      o_done,
  output logic                      o_resp_err,
  output logic [AXI_ADDR_WIDTH-1:0] o_awaddr,
  output logic                      o_awvalid,
  input  logic                      i_awready,
  output logic [AXI_DATA_WIDTH-1:0] o_wdata,
  output logic [3:0]                o_wstrb,
  output logic                      o_wvalid,
  input  logic                      i_wready,
  input  logic [1:0]                i_bresp,
  input  logic                      i_bvalid,
  output logic                      o_bready
);

  wc_state_e                 r_state;
  logic [AXI_ADDR_WIDTH-1:0] r_awaddr;
  logic [AXI_DATA_WIDTH-1:0] r_wdata;
  logic [3:0]                r_wstrb;
  logic                      r_awvalid, r_wvalid, r_bready;
  logic                      w_aw_ok, w_w_ok;

  assign w_aw_ok     = !r_awvalid || i_awready;
  assign w_w_ok      = !r_wvalid || i_wready;
  assign o_addr_done = (r_state == WC_ADDR_DATA) && w_aw_ok && w_w_ok;
  assign o_done      = (r_state == WC_RESP) && i_bvalid;
  assign o_resp_err  = o_done && (i_bresp != AXI_RESP_OKAY);

  assign o_awaddr  = r_awaddr;
  assign o_awvalid = r_awvalid;
  assign o_wdata   = r_wdata;
  assign o_wstrb   = r_wstrb;
  assign o_wvalid  = r_wvalid;
  assign o_bready  = r_bready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= WC_IDLE;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
    end else begin
      if (r_state == WC_ADDR_DATA) begin
        if (i_awready) r_awvalid <= 1'b0;
        if (i_wready)  r_wvalid  <= 1'b0;
        if (o_addr_done) begin
          r_wstrb <= '0;
          r_state <= WC_RESP;
        end
      end
      if (o_done) begin
        r_bready <= 1'b0;
        r_state  <= WC_IDLE;
      end
      // A new write may be launched on the very edge the previous response lands.
      if (i_start && (r_state == WC_IDLE || o_done)) begin
        r_awaddr  <= i_addr;
        r_wdata   <= i_data;
        r_wstrb   <= WSTRB_BYTE0;
        r_awvalid <= 1'b1;
        r_wvalid  <= 1'b1;
        r_bready  <= 1'b1;
        r_state   <= WC_ADDR_DATA;
      end
    end
  end

endmodule

// File: rtl/m_axi4l_image_sender.sv
// AXI4-Lite master: streams an image from pixel RAM to the coprocessor, pulses
// its control register, waits for ready and reads back the inferred digit.
module m_axi4l_image_sender
  import snn_axi_pkg::*;
#(
  parameter int          IMAGE_SIZE      = 256,
  parameter int          IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
  parameter int          PIXEL_BITS      = 8,
  parameter int          AXI_DATA_WIDTH  = 32,
  parameter int          AXI_ADDR_WIDTH  = 32,
  parameter int unsigned CTRL_ADDR       = CTRL_ADDR_DEF,
  parameter int unsigned RESULT_ADDR     = RESULT_ADDR_DEF
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  output logic [IMAGE_SIZE_BITS-1:0] o_pix_addr,
  input  logic [PIXEL_BITS-1:0]      i_pix_data,
  input  logic                       i_coprocessor_rdy,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [7:0]                 o_digit,
  output logic                       o_error,
  output logic [AXI_ADDR_WIDTH-1:0]  o_awaddr,
  output logic                       o_awvalid,
  input  logic                       i_awready,
  output logic [AXI_DATA_WIDTH-1:0]  o_wdata,
  output logic [3:0]                 o_wstrb,
  output logic                       o_wvalid,
  input  logic                       i_wready,
  input  logic [1:0]                 i_bresp,
  input  logic                       i_bvalid,
  output logic                       o_bready,
  output logic [AXI_ADDR_WIDTH-1:0]  o_araddr,
  output logic                       o_arvalid,
  input  logic                       i_arready,
  input  logic [AXI_DATA_WIDTH-1:0]  i_rdata,
  input  logic [1:0]                 i_rresp,
  input  logic                       i_rvalid,
  output logic                       o_rready
);

  state_e                    r_state;
  wsel_e                     r_wsel;
  logic [IMAGE_SIZE_BITS:0]  r_cnt;
  logic [IMAGE_SIZE_BITS-1:0] r_pix_addr;
  logic                      r_phase;
  logic                      r_busy, r_done, r_error;
  logic [7:0]                r_digit;
  logic [AXI_ADDR_WIDTH-1:0] r_araddr;
  logic                      r_arvalid, r_rready;

  logic [IMAGE_SIZE_BITS:0]  w_cnt_nxt;
  logic                      w_last_pix;
  logic                      w_wc_start, w_wc_addr_done, w_wc_done, w_wc_err;
  logic [AXI_ADDR_WIDTH-1:0] w_wc_addr;
  logic [AXI_DATA_WIDTH-1:0] w_wc_data;
  logic                      w_rd_fire;
  logic                      w_unused;

  assign w_unused   = &{1'b0, i_rdata[AXI_DATA_WIDTH-1:8]};
  assign w_cnt_nxt  = r_cnt + 1'b1;
  assign w_last_pix = (w_cnt_nxt == (IMAGE_SIZE_BITS+1)'(IMAGE_SIZE));

  // Pixel writes launch after the second FETCH cycle; control writes chain off the previous B.
  assign w_wc_start = (r_state == S_FETCH && r_phase) ||
                      (r_state == S_WRESP && w_wc_done &&
                       (r_wsel == WS_CTRL1 || (r_wsel == WS_PIX && w_last_pix)));

  always_comb begin
    w_wc_addr = AXI_ADDR_WIDTH'(CTRL_ADDR);
    w_wc_data = AXI_DATA_WIDTH'(1);
    if (r_state == S_FETCH) begin
      w_wc_addr = AXI_ADDR_WIDTH'(r_cnt);
      w_wc_data = AXI_DATA_WIDTH'(i_pix_data);
    end else if (r_wsel == WS_CTRL1) begin
      w_wc_data = '0;
    end
  end

  assign w_rd_fire = r_rready && i_rvalid &&
                     (r_state == S_RDATA || (r_state == S_RADDR && i_arready));

  axi4l_write_channel #(
    .AXI_DATA_WIDTH(AXI_DATA_WIDTH),
    .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH)
  ) u_wc (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (w_wc_start),
    .i_addr     (w_wc_addr),
    .i_data     (w_wc_data),
    .o_addr_done(w_wc_addr_done),
    .o_done     (w_wc_done),
    .o_resp_err (w_wc_err),
    .o_awaddr   (o_awaddr),
    .o_awvalid  (o_awvalid),
    .i_awready  (i_awready),
    .o_wdata    (o_wdata),
    .o_wstrb    (o_wstrb),
    .o_wvalid   (o_wvalid),
    .i_wready   (i_wready),
    .i_bresp    (i_bresp),
    .i_bvalid   (i_bvalid),
    .o_bready   (o_bready)
  );

  assign o_pix_addr = r_pix_addr;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_digit    = r_digit;
  assign o_error    = r_error;
  assign o_araddr   = r_araddr;
  assign o_arvalid  = r_arvalid;
  assign o_rready   = r_rready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_wsel     <= WS_PIX;
      r_cnt      <= '0;
      r_pix_addr <= '0;
      r_phase    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_digit    <= '0;
      r_araddr   <= '0;
      r_arvalid  <= 1'b0;
      r_rready   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_busy     <= 1'b1;
          r_error    <= 1'b0;
          r_cnt      <= '0;
          r_pix_addr <= '0;
          r_phase    <= 1'b0;
          r_wsel     <= WS_PIX;
          r_state    <= S_FETCH;
        end
        S_FETCH: begin
          r_phase <= !r_phase;
          if (r_phase) r_state <= S_WADDR_DATA;
        end
        S_WADDR_DATA: if (w_wc_addr_done) r_state <= S_WRESP;
        S_WRESP: if (w_wc_done) begin
          if (w_wc_err) r_error <= 1'b1;
          case (r_wsel)
            WS_PIX: begin
              r_cnt <= w_cnt_nxt;
              if (w_last_pix) begin
                r_wsel  <= WS_CTRL1;
                r_state <= S_WADDR_DATA;
              end else begin
                r_pix_addr <= w_cnt_nxt[IMAGE_SIZE_BITS-1:0];
                r_state    <= S_FETCH;
              end
            end
            WS_CTRL1: begin
              r_wsel  <= WS_CTRL0;
              r_state <= S_WADDR_DATA;
            end
            default: r_state <= S_WAIT_RDY;
          endcase
        end
        S_WAIT_RDY: if (i_coprocessor_rdy) begin
          r_araddr  <= AXI_ADDR_WIDTH'(RESULT_ADDR);
          r_arvalid <= 1'b1;
          r_rready  <= 1'b1;
          r_state   <= S_RADDR;
        end
        S_RADDR: if (i_arready) begin
          r_arvalid <= 1'b0;
          r_state   <= S_RDATA;
        end
        S_RDATA: ;
        S_FINISH: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      // Read data may arrive together with ARREADY; accept it there too.
      if (w_rd_fire) begin
        r_digit  <= i_rdata[7:0];
        r_rready <= 1'b0;
        r_done   <= 1'b1;
        r_busy   <= 1'b0;
        r_state  <= S_FINISH;
        if (i_rresp != AXI_RESP_OKAY) r_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_m_axi4l_image_sender.sv
// Bench for m_axi4l_image_sender: table of slave behaviours plus reset and busy-start sequences.
module tb_m_axi4l_image_sender;

  logic        clk, rst, start, rdy;
  logic [7:0]  pix_addr, pix_data, digit;
  logic        busy, done, error;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  m_axi4l_image_sender dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .o_pix_addr(pix_addr), .i_pix_data(pix_data),
    .i_coprocessor_rdy(rdy), .o_busy(busy), .o_done(done), .o_digit(digit), .o_error(error),
    .o_awaddr(awaddr), .o_awvalid(awvalid), .i_awready(awready), .o_wdata(wdata), .o_wstrb(wstrb),
    .o_wvalid(wvalid), .i_wready(wready), .i_bresp(bresp), .i_bvalid(bvalid), .o_bready(bready),
    .o_araddr(araddr), .o_arvalid(arvalid), .i_arready(arready), .i_rdata(rdata), .i_rresp(rresp),
    .i_rvalid(rvalid), .o_rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [256];
  always @(posedge clk) pix_data <= mem[pix_addr];

  typedef struct {
    int          awd, wd, erridx, rdyd;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    bit          same, bstart;
    int          pat;
    logic [7:0]  exp_digit;
    bit          exp_err;
  } vec_t;
  vec_t tab [5];

  int nchk, nerr;
  int c_awd, c_wd, c_erridx, c_rdyd, c_same;
  logic [31:0] c_rdata;
  logic [1:0]  c_rresp;

  int nwr, nrd, viol, rdy_cnt, aw_age, w_age;
  bit aw_got, w_got, ar_got, p_awv, p_wv, p_arv, p_awhs, p_whs, p_arhs;
  logic [31:0] cur_addr, cur_data, rd_addr;
  logic [3:0]  cur_strb;
  logic [31:0] rec_addr [512];
  logic [31:0] rec_data [512];
  logic [3:0]  rec_strb [512];
  logic        rec_err  [512];

  function automatic logic [7:0] pix(input int pat, input int i);
    logic [7:0] p;
    p = 8'(i);
    return (pat == 0) ? p : (p ^ 8'h5A);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic slave_step();
    awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
    arready = 0; rvalid = 0; rresp = 2'b00; rdata = 32'hDEAD_BEEF;
    if (rst) begin
      aw_got = 0; w_got = 0; ar_got = 0; aw_age = 0; w_age = 0;
      p_awv = 0; p_wv = 0; p_arv = 0; rdy = 0;
    end else begin
      // a VALID must hold until its READY, and drop right after it
      if ((p_awv && !p_awhs && !awvalid) || (p_wv && !p_whs && !wvalid) ||
          (p_arv && !p_arhs && !arvalid)) viol++;
      if ((awvalid && aw_got) || (wvalid && w_got) || (!awvalid && !wvalid && wstrb != 4'h0)) viol++;
      if (aw_got && w_got) begin
        if (!bready) viol++;
        else begin
          bvalid = 1;
          bresp  = (nwr == c_erridx) ? 2'b10 : 2'b00;
          if (nwr < 512) begin
            rec_addr[nwr] = cur_addr; rec_data[nwr] = cur_data;
            rec_strb[nwr] = cur_strb; rec_err[nwr]  = error;
          end
          nwr++; aw_got = 0; w_got = 0;
        end
      end
      if (awvalid && !aw_got) begin
        if (aw_age >= c_awd) begin awready = 1; aw_got = 1; aw_age = 0; cur_addr = awaddr; end
        else aw_age++;
      end
      if (wvalid && !w_got) begin
        if (w_age >= c_wd) begin wready = 1; w_got = 1; w_age = 0; cur_data = wdata; cur_strb = wstrb; end
        else w_age++;
      end
      if (arvalid && !ar_got) begin
        arready = 1; nrd++; rd_addr = araddr;
        if (c_same != 0) begin rvalid = 1; rdata = c_rdata; rresp = c_rresp; end
        else ar_got = 1;
      end else if (ar_got && rready) begin
        rvalid = 1; rdata = c_rdata; rresp = c_rresp; ar_got = 0;
      end
      if (nwr >= 258) begin
        if (rdy_cnt >= c_rdyd) rdy = 1;
        else rdy_cnt++;
      end else rdy = 0;
      p_awv = awvalid; p_awhs = awready; p_wv = wvalid; p_whs = wready; p_arv = arvalid; p_arhs = arready;
    end
  endtask

  task automatic clear_run();
    nwr = 0; nrd = 0; viol = 0; rdy_cnt = 0; rd_addr = '1;
    for (int i = 0; i < 512; i++) begin
      rec_addr[i] = 'x; rec_data[i] = 'x; rec_strb[i] = 'x; rec_err[i] = 'x;
    end
  endtask

  task automatic run_vec(input int v);
    vec_t t;
    int bad, bstr, bbusy;
    bit pulsed, seen;
    t = tab[v];
    c_awd = t.awd; c_wd = t.wd; c_erridx = t.erridx; c_rdyd = t.rdyd;
    c_rdata = t.rdata; c_rresp = t.rresp; c_same = int'(t.same);
    for (int i = 0; i < 256; i++) mem[i] = pix(t.pat, i);
    clear_run();
    start = 1; @(posedge clk); #2; start = 0;
    chk("busy_after_start", busy, 1);
    chk("err_clr_on_start", error, 0);
    bbusy = 0; pulsed = 0; seen = 0;
    for (int c = 0; c < 20000 && !seen; c++) begin
      @(posedge clk); #2; start = 0;
      if (done) seen = 1;
      else begin
        if (!busy) bbusy++;
        if (t.bstart && !pulsed && nwr == 50) begin start = 1; pulsed = 1; end
      end
    end
    chk("done_seen", seen, 1);
    chk("digit", digit, t.exp_digit);
    chk("error_final", error, t.exp_err);
    chk("busy_at_done", busy, 0);
    chk("busy_during_run", bbusy, 0);
    if (t.bstart) start = 1;
    @(posedge clk); #2; start = 0;
    chk("done_one_cycle", done, 0);
    chk("busy_after_finish", busy, 0);
    @(posedge clk); #2;
    chk("start_in_finish_ignored", busy, 0);
    chk("digit_held", digit, t.exp_digit);
    chk("n_writes", nwr, 258);
    bad = 0; bstr = 0;
    for (int i = 0; i < 256; i++)
      if (rec_addr[i] !== i || rec_data[i] !== {24'h0, pix(t.pat, i)}) bad++;
    for (int i = 0; i < 258; i++) if (rec_strb[i] !== 4'h1) bstr++;
    chk("pixel_writes_bad", bad, 0);
    chk("wstrb_bad", bstr, 0);
    chk("ctrl1_addr", rec_addr[256], 256);
    chk("ctrl1_data", rec_data[256], 1);
    chk("ctrl0_addr", rec_addr[257], 256);
    chk("ctrl0_data", rec_data[257], 0);
    chk("err_after_px17", rec_err[18], (t.erridx == 17) ? 1 : 0);
    chk("n_reads", nrd, 1);
    chk("araddr", rd_addr, 0);
    chk("protocol_viol", viol, 0);
  endtask

  initial begin
    int found;
    nchk = 0; nerr = 0; rst = 1; start = 0; rdy = 0;
    c_awd = 0; c_wd = 0; c_erridx = -1; c_rdyd = 0; c_same = 0; c_rdata = 0; c_rresp = 0;
    tab[0] = '{awd:0, wd:0, erridx:-1, rdyd:300, rdata:32'd5,     rresp:2'b00, same:0, bstart:0, pat:0, exp_digit:8'd5,    exp_err:0};
    tab[1] = '{awd:3, wd:0, erridx:-1, rdyd:0,   rdata:32'd9,     rresp:2'b00, same:0, bstart:0, pat:1, exp_digit:8'd9,    exp_err:0};
    tab[2] = '{awd:1, wd:2, erridx:17, rdyd:10,  rdata:32'h1A3,   rresp:2'b00, same:0, bstart:0, pat:0, exp_digit:8'hA3,   exp_err:1};
    tab[3] = '{awd:0, wd:1, erridx:-1, rdyd:4,   rdata:32'd7,     rresp:2'b00, same:1, bstart:1, pat:1, exp_digit:8'd7,    exp_err:0};
    tab[4] = '{awd:2, wd:2, erridx:-1, rdyd:0,   rdata:32'hFF03,  rresp:2'b10, same:0, bstart:0, pat:0, exp_digit:8'd3,    exp_err:1};
    clear_run();
    fork
      forever begin @(posedge clk); #1; slave_step(); end
    join_none
    repeat (3) @(posedge clk);
    #2;
    chk("rst_valids", {27'h0, awvalid, wvalid, bready, arvalid, rready}, 0);
    chk("rst_status", {29'h0, busy, done, error}, 0);
    chk("rst_digit", digit, 0);
    chk("rst_pix_addr", pix_addr, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_wstrb", wstrb, 0);
    chk("rst_araddr", araddr, 0);
    rst = 0;
    @(posedge clk); #2;

    for (int v = 0; v < 5; v++) run_vec(v);

    // Reset while pixel 100 sits in the address/data phase, after an error response.
    c_awd = 4; c_wd = 0; c_erridx = 17; c_rdyd = 0; c_same = 0;
    clear_run();
    start = 1; @(posedge clk); #2; start = 0;
    found = 0;
    for (int c = 0; c < 20000 && found == 0; c++) begin
      @(posedge clk); #2;
      if (nwr == 100 && awvalid) found = 1;
    end
    chk("reach_px100", found, 1);
    chk("err_before_rst", error, 1);
    rst = 1; @(posedge clk); #2;
    chk("midrst_valids", {29'h0, awvalid, wvalid, arvalid}, 0);
    chk("midrst_busy_err", {30'h0, busy, error}, 0);
    rst = 0; @(posedge clk); #2;
    run_vec(1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
